// File: rtl/sw_in_port_debounce_if.sv
// Switch input-port bundle between the MEM stage (master) and the debouncer (slave).
// The master drives the raw switches and the read strobes; the slave returns the ports and flags.
interface sw_in_port_debounce_if;
    logic [9:0]  sw;
    logic        rd_port0;
    logic        rd_port1;
    logic [31:0] in_port0;
    logic [31:0] in_port1;
    logic        chg0;
    logic        chg1;
    logic [9:0]  sw_stable;

    modport master (
        output sw, rd_port0, rd_port1,
        input  in_port0, in_port1, chg0, chg1, sw_stable
    );

    modport slave (
        input  sw, rd_port0, rd_port1,
        output in_port0, in_port1, chg0, chg1, sw_stable
    );
endinterface

// File: rtl/sw_in_port_debounce.sv
// Two-flop synchroniser and per-bit debounce for SW9..SW0, exposed as input ports 0x80/0x84
// with sticky "changed since last read" flags.
module sw_in_port_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    sw_in_port_debounce_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [9:0]       s1_q, s2_q;
    logic [9:0]       stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [10];
    logic [CNT_W-1:0] cnt_d [10];
    logic             chg0_q, chg0_d;
    logic             chg1_q, chg1_d;

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 10; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end

        // A read strobe clears the flag, but a change landing in the same cycle wins.
        chg0_d = chg0_q;
        if (bus.rd_port0) chg0_d = 1'b0;
        if (stable_d[9:5] != stable_q[9:5]) chg0_d = 1'b1;

        chg1_d = chg1_q;
        if (bus.rd_port1) chg1_d = 1'b0;
        if (stable_d[4:0] != stable_q[4:0]) chg1_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            chg0_q   <= 1'b0;
            chg1_q   <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= bus.sw;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            chg0_q   <= chg0_d;
            chg1_q   <= chg1_d;
            for (int i = 0; i < 10; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.in_port0  = {27'b0, stable_q[9:5]};
    assign bus.in_port1  = {27'b0, stable_q[4:0]};
    assign bus.chg0      = chg0_q;
    assign bus.chg1      = chg1_q;
    assign bus.sw_stable = stable_q;

endmodule

// File: tb/tb_sw_in_port_debounce.sv
// Directed bench for sw_in_port_debounce with DEBOUNCE_CYCLES = 4; expected port states are
// queued as stimulus is driven and popped at each sampled edge.
module tb_sw_in_port_debounce;

    localparam int DEB = 4;

    typedef struct {
        string      tag;
        logic [9:0] st;
        logic       c0;
        logic       c1;
    } exp_t;

    logic  clock = 1'b0;
    logic  reset;
    exp_t  sb[$];
    int    vectors     = 0;
    int    miscompares = 0;

    sw_in_port_debounce_if bus ();

    sw_in_port_debounce #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic want(input string tag, input logic [9:0] st, input logic c0, input logic c1);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.c0  = c0;
        e.c1  = c1;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_underflow observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        cmp(e.tag, "in_port0",  bus.in_port0,  {27'b0, e.st[9:5]});
        cmp(e.tag, "in_port1",  bus.in_port1,  {27'b0, e.st[4:0]});
        cmp(e.tag, "sw_stable", {22'b0, bus.sw_stable}, {22'b0, e.st});
        cmp(e.tag, "chg0",      {31'b0, bus.chg0}, {31'b0, e.c0});
        cmp(e.tag, "chg1",      {31'b0, bus.chg1}, {31'b0, e.c1});
    endtask

    task automatic expect_run(input string tag, input int n_wait, input logic [9:0] st_old,
                              input logic [9:0] st_new, input logic c0, input logic c1);
        for (int i = 0; i < n_wait; i++) want(tag, st_old, 1'b0, 1'b0);
        want(tag, st_new, c0, c1);
        for (int i = 0; i <= n_wait; i++) begin
            tick();
            check_out();
        end
    endtask

    initial begin
        reset        = 1'b0;
        bus.sw       = 10'h3FF;
        bus.rd_port0 = 1'b0;
        bus.rd_port1 = 1'b0;
        repeat (2) tick();

        // Reset asserted between edges must clear outputs without a clock edge.
        @(negedge clock);
        #1 reset = 1'b1;
        want("rst_async", 10'h000, 1'b0, 1'b0);
        #1 check_out();
        repeat (2) tick();
        bus.sw = 10'h000;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) want("rst_idle", 10'h000, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_out();
        end

        // Clean press of SW9 and SW0: accepted at edge DEB+2.
        bus.sw = 10'b10_0000_0001;
        expect_run("press", DEB + 1, 10'h000, 10'h201, 1'b1, 1'b1);
        bus.rd_port0 = 1'b1;
        bus.rd_port1 = 1'b1;
        want("press_clr", 10'h201, 1'b0, 1'b0);
        tick();
        check_out();
        bus.rd_port0 = 1'b0;
        bus.rd_port1 = 1'b0;

        bus.sw = 10'h000;
        expect_run("release", DEB + 1, 10'h201, 10'h000, 1'b1, 1'b1);
        bus.rd_port0 = 1'b1;
        bus.rd_port1 = 1'b1;
        want("release_clr", 10'h000, 1'b0, 1'b0);
        tick();
        check_out();
        bus.rd_port0 = 1'b0;
        bus.rd_port1 = 1'b0;

        // SW3 bounce: one-cycle toggles, then a held rise.
        for (int i = 0; i < 4; i++) begin
            bus.sw = (i % 2 == 0) ? 10'h008 : 10'h000;
            want("bounce_tgl", 10'h000, 1'b0, 1'b0);
            tick();
            check_out();
        end
        bus.sw = 10'h008;
        expect_run("bounce_hold", DEB + 1, 10'h000, 10'h008, 1'b0, 1'b1);
        bus.rd_port1 = 1'b1;
        want("bounce_clr", 10'h008, 1'b0, 1'b0);
        tick();
        check_out();
        bus.rd_port1 = 1'b0;

        // SW7 glitch of DEB-1 cycles must be rejected.
        bus.sw = 10'h088;
        for (int i = 0; i < 10; i++) want("glitch", 10'h008, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) bus.sw = 10'h008;
            tick();
            check_out();
        end

        // SW6 acceptance coincides with a port-0 read: set wins.
        bus.sw = 10'h048;
        for (int i = 0; i < DEB + 1; i++) want("collide_wait", 10'h008, 1'b0, 1'b0);
        for (int i = 0; i < DEB + 1; i++) begin
            tick();
            check_out();
        end
        bus.rd_port0 = 1'b1;
        want("collide_set", 10'h048, 1'b1, 1'b0);
        tick();
        check_out();
        bus.rd_port0 = 1'b0;
        bus.rd_port1 = 1'b1;
        want("other_strobe", 10'h048, 1'b1, 1'b0);
        tick();
        check_out();
        bus.rd_port1 = 1'b0;
        bus.rd_port0 = 1'b1;
        want("read_clr", 10'h048, 1'b0, 1'b0);
        tick();
        check_out();
        bus.rd_port0 = 1'b0;

        // Reset while SW0's count is at 2; acceptance restarts from release.
        bus.sw = 10'h001;
        for (int i = 0; i < 4; i++) want("midcnt_wait", 10'h048, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out();
        end
        @(negedge clock);
        #1 reset = 1'b1;
        want("midcnt_rst", 10'h000, 1'b0, 1'b0);
        #1 check_out();
        repeat (2) tick();
        reset = 1'b0;
        expect_run("midcnt_acc", DEB + 1, 10'h000, 10'h001, 1'b0, 1'b1);

        vectors++;
        assert (sb.size() == 0)
        else begin
            miscompares++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/sw_in_port_debounce.md
# sw_in_port_debounce

Synchronises and debounces the ten board slide switches (SW9..SW0) and presents them as the two memory-mapped input ports (0x80, 0x84) read by the pipelined computer's MEM stage. It sits directly upstream of the data-memory/IO stage and replaces raw switch wiring into `in_port0`/`in_port1`. It also provides per-port sticky "changed since last read" flags, so software can poll cheaply.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: clock cycles an input must stay at its new level before it is accepted. Must be ≥ 2.
- `CNT_W`, default 16: width of each per-bit debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clock`  in  1: system clock. One clock; all state is on its rising edge.
- `reset`  in  1: reset is asynchronous and active-high.
- `sw`  in  10: raw switch inputs, asynchronous to `clock`. Bit i = SWi.
- `rd_port0`  in  1: one-cycle strobe from the MEM stage when a load to 0x80 completes.
- `rd_port1`  in  1: one-cycle strobe for a load to 0x84.
- `in_port0`  out  32: {27'b0, stable[9:5]}. SW9 is bit 4.
- `in_port1`  out  32: {27'b0, stable[4:0]}. SW4 is bit 4.
- `chg0`  out  1: sticky flag. A bit of stable[9:5] has changed since the last `rd_port0`.
- `chg1`  out  1: sticky flag. A bit of stable[4:0] has changed since the last `rd_port1`.
- `sw_stable`  out  10: debounced switch vector, for observation.

## Operation
- **Synchroniser:** each `sw` bit passes through two flops (`s1` then `s2`) before any other use. No logic sits between `s1` and `s2`.
- **Per-bit debounce:** there is an independent counter `cnt[i]` and state bit `stable[i]` for each switch.
  - If `s2[i] == stable[i]`: `cnt[i]` is cleared to 0.
  - If `s2[i] != stable[i]` and `cnt[i] < DEBOUNCE_CYCLES-1`: `cnt[i]` increments.
  - If `s2[i] != stable[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`: `stable[i]` takes `s2[i]` and `cnt[i]` clears to 0.
  - Counters never wrap. The maximum value held is DEBOUNCE_CYCLES-1.
- **Glitch rejection:** any return of `s2[i]` to `stable[i]` before acceptance clears `cnt[i]`. A later deviation restarts the count from 0.
- **Change flags:** `chg0` sets on any cycle where stable[9:5] is updated to a different value. `chg1` behaves the same for stable[4:0].
  - The flag clears on the cycle after its read strobe.
  - If a set and the matching strobe occur in the same cycle, set wins and the flag stays 1.
  - Strobes for the other port do not affect a flag.
- **Outputs:** all outputs are registered or are direct wiring of registers. There is no combinational path from `sw` or the strobes to any output.
- **Reset values:** asserting `reset` immediately forces `s1`, `s2`, `stable`, every `cnt[i]`, `chg0` and `chg1` to 0. Therefore `in_port0 = in_port1 = 0` and `sw_stable = 0`.
- **Switches held at reset release:** switches already high when `reset` deasserts are accepted through the normal debounce path. The flags then set, so software sees them as a change.
- **Reset mid-count:** reset during a count aborts the count. No partial acceptance survives reset.

## Timing
- **Acceptance latency:** let `sw[i]` change before rising edge 1 and hold. Then:
  - `s1` captures it at edge 1 and `s2` at edge 2.
  - `cnt[i]` = k after edge 2+k.
  - `stable[i]`, `in_portX` and `sw_stable[i]` update at edge DEBOUNCE_CYCLES+2.
  - `chgX` rises at the same edge.
- **Rejection threshold:** a pulse whose `s2` duration is ≤ DEBOUNCE_CYCLES-1 cycles is never accepted.
- **Flag clear latency:** a strobe sampled at edge n clears the flag at edge n, so the flag reads 0 from edge n onward. This holds unless a set coincides at edge n.
- **Independence:** all ten bits are independent. Simultaneous changes on several bits of one port produce a single `chg` set.

## Test plan
Run with `DEBOUNCE_CYCLES`=4.
1. **Reset:** assert `reset` mid-cycle with `sw`=10'h3FF → outputs 0 immediately, asynchronously. Release with `sw`=0 → all outputs stay 0 for 20 cycles.
2. **Clean press:** `sw`=10'b10_0000_0001 set before edge 1.
   - Edge 5: nothing has changed.
   - Edge 6: `in_port0`=32'h10, `in_port1`=32'h1, `chg0`=`chg1`=1.
3. **Bounce:** SW3 toggles 1,0,1,0 with one-cycle periods, then holds 1 → no acceptance during the toggling. `in_port1` becomes 32'h8 exactly 6 edges after the final rise.
4. **Glitch:** a 3-cycle-wide high pulse on SW7 → `in_port0` stays 0 and `chg0` stays 0 throughout.
5. **Strobe vs set collision:**
   - Pulse `rd_port0` on the same edge SW6's acceptance lands → `chg0` stays 1.
   - A second `rd_port0` alone → `chg0`=0.
   - `rd_port1` never alters `chg0`.
6. **Reset mid-count:** SW0 high, assert `reset` after `cnt` reaches 2, release → acceptance occurs 6 edges after release, and `in_port1` is never 1 earlier.
